multi_sched: RTL and testbench

- Round-robin scheduler that shares one 8x8 multiplier datapath between REQ_NUM requesters.
- Sits between requester ports (PE lanes, address-gen) and the multiplier instance.
- Accepts one operand pair at a time, issues it, waits for the result with a timeout, and routes the result back to the owning requester.
- Exactly one operation is outstanding at any time.

---
 rtl/multi_sched_pkg.sv | 24 ++
 rtl/multi_sched_if.sv | 32 +++
 rtl/multi_sched_rr_arb.sv | 31 +++
 rtl/multi_sched.sv | 142 ++++++++++++++
 tb/tb_multi_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/multi_sched_pkg.sv
// Shared types and helpers for the multiplier scheduler and its arbiter.
package multi_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } sched_state_e;

   localparam int MUL_DW = 8;
   localparam int MUL_RW = 16;

   // Ceiling log2, never below 1 so it can size an index of a 1-entry vector.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         r = ((1 << r) < n) ? r + 1 : r;
      end
      return r;
   endfunction

endpackage

// File: rtl/multi_sched_if.sv
// Requester and multiplier-side bundle; master is the scheduler, slave is its environment.
interface multi_sched_if
   import multi_pkg::*;
#(
   parameter int REQ_NUM = 4,
   parameter int DATA_W  = MUL_DW
);
   logic [REQ_NUM-1:0]        req_vld;
   logic [REQ_NUM*DATA_W-1:0] req_a;
   logic [REQ_NUM*DATA_W-1:0] req_b;
   logic [REQ_NUM-1:0]        req_rdy;
   logic [REQ_NUM-1:0]        rsp_vld;
   logic [2*DATA_W-1:0]       rsp_data;
   logic                      rsp_err;
   logic [REQ_NUM-1:0]        rsp_rdy;
   logic                      mul_vld;
   logic [DATA_W-1:0]         mul_a;
   logic [DATA_W-1:0]         mul_b;
   logic                      mul_busy;
   logic                      mul_done_vld;
   logic [2*DATA_W-1:0]       mul_res;

   modport master (
      input  req_vld, req_a, req_b, rsp_rdy, mul_busy, mul_done_vld, mul_res,
      output req_rdy, rsp_vld, rsp_data, rsp_err, mul_vld, mul_a, mul_b
   );

   modport slave (
      output req_vld, req_a, req_b, rsp_rdy, mul_busy, mul_done_vld, mul_res,
      input  req_rdy, rsp_vld, rsp_data, rsp_err, mul_vld, mul_a, mul_b
   );
endinterface

// File: rtl/multi_sched_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arb
   import multi_pkg::*;
#(
   parameter  int REQ_NUM = 4,
   localparam int IDX_W   = clog2(REQ_NUM)
) (
   input  logic [REQ_NUM-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [REQ_NUM-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any
);

   // Scan from ptr upward; the first hit wins and masks the rest.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int i = 0; i < REQ_NUM; i++) begin
         int unsigned idx;
         logic        hit;
         idx      = (int'(ptr) + i) % REQ_NUM;
         hit      = req[idx] & ~any;
         gnt[idx] = hit;
         gnt_idx  = hit ? IDX_W'(idx) : gnt_idx;
         any      = any | req[idx];
      end
   end

endmodule

// File: rtl/multi_sched.sv
// Round-robin scheduler sharing one multiplier; one operation in flight, with timeout.
module multi_sched
   import multi_pkg::*;
#(
   parameter  int REQ_NUM = 4,
   parameter  int DATA_W  = MUL_DW,
   parameter  int TMO_CYC = 64,
   localparam int IDX_W   = clog2(REQ_NUM),
   localparam int TMO_W   = clog2(TMO_CYC)
) (
   input  logic          clk,
   input  logic          rst_n,
   multi_sched_if.master bus,
   output logic          sched_busy
);

   sched_state_e        state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic                mul_vld_q, mul_vld_d;
   logic [DATA_W-1:0]   mul_a_q, mul_a_d;
   logic [DATA_W-1:0]   mul_b_q, mul_b_d;
   logic [REQ_NUM-1:0]  rsp_vld_q, rsp_vld_d;
   logic [2*DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;

   logic [REQ_NUM-1:0]  gnt_s;
   logic [IDX_W-1:0]    gnt_idx_s;
   logic                any_s;
   logic                grant_s;
   logic [REQ_NUM-1:0]  owner_oh_s;

   rr_arb #(.REQ_NUM(REQ_NUM)) u_arb (
      .req     (bus.req_vld),
      .ptr     (rr_ptr_q),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s),
      .any     (any_s)
   );

   // Accept is only offered while idle, out of reset, and with the multiplier free.
   assign grant_s    = (state_q == S_IDLE) & any_s & ~bus.mul_busy & ~rst_n;
   assign owner_oh_s = {{(REQ_NUM-1){1'b0}}, 1'b1} << owner_q;

   assign bus.req_rdy  = grant_s ? gnt_s : '0;
   assign bus.mul_vld  = mul_vld_q;
   assign bus.mul_a    = mul_a_q;
   assign bus.mul_b    = mul_b_q;
   assign bus.rsp_vld  = rsp_vld_q;
   assign bus.rsp_data = rsp_data_q;
   assign bus.rsp_err  = rsp_err_q;
   assign sched_busy   = (state_q != S_IDLE);

   // Next-state and next-output computation for the IDLE/ISSUE/WAIT/RESP sequence.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      tmo_cnt_d  = tmo_cnt_q;
      mul_vld_d  = 1'b0;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      rsp_vld_d  = rsp_vld_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (grant_s) begin
               owner_d   = gnt_idx_s;
               mul_a_d   = bus.req_a[int'(gnt_idx_s)*DATA_W +: DATA_W];
               mul_b_d   = bus.req_b[int'(gnt_idx_s)*DATA_W +: DATA_W];
               mul_vld_d = 1'b1;
               state_d   = S_ISSUE;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_ISSUE: begin
            tmo_cnt_d = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            // A result arriving on the last timeout cycle still counts as success.
            if (bus.mul_done_vld) begin
               rsp_data_d = bus.mul_res;
               rsp_err_d  = 1'b0;
               rsp_vld_d  = owner_oh_s;
               state_d    = S_RESP;
            end else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               rsp_vld_d  = owner_oh_s;
               state_d    = S_RESP;
            end else begin
               state_d    = S_WAIT;
            end
         end
         S_RESP: begin
            if (bus.rsp_rdy[owner_q]) begin
               rsp_vld_d = '0;
               rr_ptr_d  = (owner_q == IDX_W'(REQ_NUM - 1)) ? '0 : owner_q + IDX_W'(1);
               state_d   = S_IDLE;
            end else begin
               state_d   = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         tmo_cnt_q  <= '0;
         mul_vld_q  <= 1'b0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         rsp_vld_q  <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         tmo_cnt_q  <= tmo_cnt_d;
         mul_vld_q  <= mul_vld_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_multi_sched.sv
// Randomised bench for multi_sched against a transaction-level scheduler model.
module tb_multi_sched;
   import multi_pkg::*;

   localparam int RN  = 4;
   localparam int DW  = 8;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst_n;
   logic sched_busy;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   exp_ptr = 0;

   multi_sched_if #(.REQ_NUM(RN), .DATA_W(DW)) bus ();

   multi_sched #(.REQ_NUM(RN), .DATA_W(DW), .TMO_CYC(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.master),
      .sched_busy (sched_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model arbitration: first asserted requester at or after the pointer, wrapping.
   function automatic int pick(input logic [RN-1:0] m, input int p);
      for (int i = 0; i < RN; i++) begin
         int idx;
         idx = (p + i) % RN;
         if (m[idx]) return idx;
      end
      return -1;
   endfunction

   // One full transaction; d = cycles from issue to done (d > TMO means never), k = backpressure cycles.
   task automatic run_op(input logic [RN-1:0] mask, input logic [31:0] a_all, input logic [31:0] b_all,
                         input int busy_cyc, input int d, input int k, input logic keep_req,
                         output int g, output int acc_cyc);
      logic [DW-1:0]   va, vb;
      logic [2*DW-1:0] exp_d, hd;
      logic            exp_e, he, quiet_bad;
      logic [RN-1:0]   oh;
      int              lat, exp_lat;
      bus.req_a   = a_all;
      bus.req_b   = b_all;
      bus.req_vld = mask;
      for (int i = 0; i < busy_cyc; i++) begin
         bus.mul_busy     = 1'b1;
         bus.mul_done_vld = 1'($urandom);
         #1;
         check_eq("busy_no_rdy", 32'(bus.req_rdy), 32'd0);
         tick();
      end
      bus.mul_busy     = 1'b0;
      bus.mul_done_vld = 1'b0;
      #1;
      g       = pick(mask, exp_ptr);
      oh      = RN'(1) << g;
      va      = a_all[g*DW +: DW];
      vb      = b_all[g*DW +: DW];
      exp_d   = (d <= TMO) ? 16'(va) * 16'(vb) : 16'd0;
      exp_e   = (d > TMO);
      exp_lat = (d <= TMO) ? d + 2 : TMO + 2;
      check_eq("grant", 32'(bus.req_rdy), 32'(oh));
      acc_cyc = cyc;
      tick();
      if (!keep_req) bus.req_vld = RN'($urandom);
      bus.mul_done_vld = 1'($urandom);
      bus.mul_res      = 16'($urandom);
      #1;
      check_eq("issue_vld", 32'(bus.mul_vld), 32'd1);
      check_eq("issue_ab", {16'd0, bus.mul_a, bus.mul_b}, {16'd0, va, vb});
      lat       = -1;
      quiet_bad = 1'b0;
      for (int n = 2; n < TMO + 20; n++) begin
         tick();
         bus.mul_done_vld = (n == d + 1);
         bus.mul_res      = (n == d + 1) ? 16'(va) * 16'(vb) : 16'($urandom);
         #1;
         if (bus.rsp_vld != '0) begin
            lat = n;
            break;
         end
         if (bus.mul_vld || bus.req_rdy != '0) quiet_bad = 1'b1;
      end
      check_eq("latency", 32'(lat), 32'(exp_lat));
      check_eq("rsp_vld", 32'(bus.rsp_vld), 32'(oh));
      check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp_d));
      check_eq("rsp_err", 32'(bus.rsp_err), 32'(exp_e));
      hd = bus.rsp_data;
      he = bus.rsp_err;
      for (int i = 0; i < k; i++) begin
         bus.rsp_rdy      = RN'($urandom) & ~oh;
         bus.mul_done_vld = 1'($urandom);
         bus.mul_res      = 16'($urandom);
         tick();
         if (bus.rsp_vld != oh || bus.rsp_data != hd || bus.rsp_err != he ||
             bus.mul_vld || bus.req_rdy != '0 || !sched_busy) quiet_bad = 1'b1;
      end
      check_eq("quiet_hold", 32'(quiet_bad), 32'd0);
      bus.rsp_rdy      = RN'($urandom) | oh;
      bus.mul_done_vld = 1'b0;
      tick();
      check_eq("rsp_drop", 32'(bus.rsp_vld), 32'd0);
      check_eq("idle_busy", 32'(sched_busy), 32'd0);
      exp_ptr = (g + 1) % RN;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq(tag, {bus.req_rdy, bus.rsp_vld, 3'd0, bus.rsp_err, 3'd0, bus.mul_vld, 3'd0, sched_busy, 8'd0},
               32'd0);
      check_eq(tag, {bus.rsp_data, bus.mul_a, bus.mul_b}, 32'd0);
   endtask

   initial begin
      int g, acc, prev_acc;
      rst_n            = 1'b1;
      bus.req_vld      = 4'hF;
      bus.req_a        = 32'd0;
      bus.req_b        = 32'd0;
      bus.rsp_rdy      = 4'h0;
      bus.mul_busy     = 1'b0;
      bus.mul_done_vld = 1'b0;
      bus.mul_res      = 16'd0;
      repeat (3) tick();
      check_eq("rst_no_rdy", 32'(bus.req_rdy), 32'd0);
      bus.req_vld = 4'h0;
      rst_n       = 1'b0;
      tick();
      check_all_zero("reset_state");

      // Fairness: all requesting, done one cycle after issue, responses accepted at once.
      prev_acc = 0;
      for (int i = 0; i < 5; i++) begin
         run_op(4'hF, $urandom, $urandom, 0, 1, 0, 1'b1, g, acc);
         check_eq("fair_order", 32'(g), 32'(i % RN));
         if (i > 0) check_eq("fair_spacing", 32'(acc - prev_acc), 32'd4);
         prev_acc = acc;
      end
      bus.req_vld = 4'h0;
      tick();

      // Single known op on requester 1 (5*3), then backpressure on requester 2.
      exp_ptr = 1;
      run_op(4'b0010, 32'h0000_0500, 32'h0000_0300, 0, 1, 0, 1'b0, g, acc);
      check_eq("single_owner", 32'(g), 32'd1);
      run_op(4'b0100, $urandom, $urandom, 0, 2, 10, 1'b0, g, acc);
      check_eq("bp_owner", 32'(g), 32'd2);

      // Timeout (never done), done on the last timeout cycle, then normal traffic.
      run_op(4'($urandom | 1), $urandom, $urandom, 0, 1000, 2, 1'b0, g, acc);
      run_op(4'hF, $urandom, $urandom, 0, TMO, 1, 1'b0, g, acc);
      run_op(4'hF, $urandom, $urandom, 0, 3, 0, 1'b0, g, acc);

      // Multiplier busy while everyone requests.
      run_op(4'hF, $urandom, $urandom, 6, 1, 0, 1'b0, g, acc);

      for (int i = 0; i < 30; i++) begin
         logic [RN-1:0] m;
         m = RN'($urandom);
         if (m == '0) m = RN'(1) << $urandom_range(RN - 1, 0);
         run_op(m, $urandom, $urandom, $urandom_range(2, 0),
                ($urandom_range(9, 0) == 0) ? TMO + 5 : $urandom_range(6, 1),
                $urandom_range(3, 0), 1'($urandom), g, acc);
      end

      // Reset during WAIT, then a late done from the abandoned op.
      bus.req_vld = 4'hF;
      bus.mul_busy = 1'b0;
      bus.mul_done_vld = 1'b0;
      #1;
      tick();
      bus.req_vld = 4'h0;
      tick();
      tick();
      check_eq("mid_in_wait", 32'(sched_busy), 32'd1);
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
      check_all_zero("mid_reset");
      bus.mul_done_vld = 1'b1;
      bus.mul_res      = 16'hBEEF;
      tick();
      bus.mul_done_vld = 1'b0;
      repeat (3) tick();
      check_all_zero("late_done_ignored");
      exp_ptr = 0;
      run_op(4'hF, $urandom, $urandom, 0, 1, 0, 1'b0, g, acc);
      check_eq("post_rst_owner", 32'(g), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
